// File: rtl/mips_decode_exec_pkg.sv
// ---------------------------------------------------------------------------
// mips_decode_exec_pkg
// Shared definitions for the MIPS decode/execute slice. It holds the opcode
// and funct constants, the ALU operation, immediate-extension and next-PC
// encodings, the control bundle, and the immediate extender helper.
// Optional feature macro: MIPS_SLT_EN (enables slt/sltu/slti decode).
// ---------------------------------------------------------------------------
package mips_decode_exec_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_XOR  = 3'b100,
        ALU_NOR  = 3'b101,
        ALU_SLT  = 3'b110,
        ALU_SLTU = 3'b111
    } alu_ctr_e;

    typedef enum logic [1:0] {
        EXT_ZERO = 2'b00,
        EXT_SIGN = 2'b01,
        EXT_LUI  = 2'b10
    } ext_op_e;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_BEQ  = 2'b01,
        NPC_JUMP = 2'b10
    } npc_sel_e;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type funct codes
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    typedef struct packed {
        logic     reg_dst;
        logic     alu_src;
        logic     mem2reg;
        logic     mem_write;
        logic     reg_write;
        alu_ctr_e alu_ctr;
        ext_op_e  ext_op;
        npc_sel_e npc_sel;
    } ctrl_t;

    function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_op_e op);
        case (op)
            EXT_SIGN: return {{16{imm[15]}}, imm};
            EXT_LUI:  return {imm, 16'h0000};
            default:  return {16'h0000, imm};
        endcase
    endfunction

endpackage

// File: rtl/mips_alu.sv
// ---------------------------------------------------------------------------
// mips_alu
// Purely combinational 32-bit ALU. ADD/SUB wrap with no overflow trap;
// SLT compares signed, SLTU unsigned, both giving 0 or 1.
// Ports:
//   i_srcA, i_srcB  32-bit operands
//   i_aluCtr        operation select
//   o_result        32-bit result
//   o_zero          high when o_result is zero
// ---------------------------------------------------------------------------
module mips_alu
    import mips_decode_exec_pkg::*;
(
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    input  alu_ctr_e    i_aluCtr,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        // NOTE: every signal written in always_comb gets a value on every
        // path (default first), otherwise synthesis infers a latch.
        o_result = '0;
        case (i_aluCtr)
            ALU_ADD:  o_result = i_srcA + i_srcB;
            ALU_SUB:  o_result = i_srcA - i_srcB;
            ALU_AND:  o_result = i_srcA & i_srcB;
            ALU_OR:   o_result = i_srcA | i_srcB;
            ALU_XOR:  o_result = i_srcA ^ i_srcB;
            ALU_NOR:  o_result = ~(i_srcA | i_srcB);
            ALU_SLT:  o_result = {31'd0, $signed(i_srcA) < $signed(i_srcB)};
            ALU_SLTU: o_result = {31'd0, i_srcA < i_srcB};
            default:  o_result = '0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_decode_exec.sv
// ---------------------------------------------------------------------------
// mips_decode_exec
// Single-cycle MIPS decode/execute slice: field split, main/ALU control
// decode, immediate extension, operand select and ALU, all outputs
// registered (1-cycle latency, one instruction per cycle).
// Optional feature macro: MIPS_SLT_EN -- when undefined, slt/sltu/slti
// decode as no-ops.
// Ports:
//   clk, reset (synchronous, active-high)
//   i_instr, i_busA, i_busB   instruction word and rs/rt register values
//   o_opcode..o_imm26         registered instruction fields
//   o_rw                      destination register (rd if regDst else rt)
//   o_aluResu, o_zero         ALU result and zero flag
//   o_regDst..o_nPC_sel       datapath controls
//   o_pcReset                 registered copy of reset
// ---------------------------------------------------------------------------
module mips_decode_exec
    import mips_decode_exec_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_busA,
    input  logic [31:0] i_busB,
    output logic [5:0]  o_opcode,
    output logic [5:0]  o_funct,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_rd,
    output logic [4:0]  o_shamt,
    output logic [15:0] o_imm16,
    output logic [25:0] o_imm26,
    output logic [4:0]  o_rw,
    output logic [31:0] o_aluResu,
    output logic        o_zero,
    output logic        o_regDst,
    output logic        o_aluSrc,
    output logic        o_mem2Reg,
    output logic        o_memWrite,
    output logic        o_regWrite,
    output logic [2:0]  o_aluCtr,
    output logic [1:0]  o_ext_op,
    output logic [1:0]  o_nPC_sel,
    output logic        o_pcReset
);

    logic [5:0]  w_opcode;
    logic [5:0]  w_funct;
    ctrl_t       w_ctrl;
    logic [31:0] w_srcB;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;

    logic [31:0] r_instr;
    ctrl_t       r_ctrl;
    logic [4:0]  r_rw;
    logic [31:0] r_alu_res;
    logic        r_zero;
    logic        r_pc_reset;

    assign w_opcode = i_instr[31:26];
    assign w_funct  = i_instr[5:0];

    // Main and ALU control decode; anything unrecognised stays a no-op.
    always_comb begin
        w_ctrl = '0;
        case (w_opcode)
            OP_RTYPE: begin
                w_ctrl.reg_dst   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                case (w_funct)
                    FN_ADD, FN_ADDU: w_ctrl.alu_ctr = ALU_ADD;
                    FN_SUB, FN_SUBU: w_ctrl.alu_ctr = ALU_SUB;
                    FN_AND:          w_ctrl.alu_ctr = ALU_AND;
                    FN_OR:           w_ctrl.alu_ctr = ALU_OR;
                    FN_XOR:          w_ctrl.alu_ctr = ALU_XOR;
                    FN_NOR:          w_ctrl.alu_ctr = ALU_NOR;
`ifdef MIPS_SLT_EN
                    FN_SLT:          w_ctrl.alu_ctr = ALU_SLT;
                    FN_SLTU:         w_ctrl.alu_ctr = ALU_SLTU;
`endif
                    default:         w_ctrl = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.ext_op    = EXT_SIGN;
            end
`ifdef MIPS_SLT_EN
            OP_SLTI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.ext_op    = EXT_SIGN;
                w_ctrl.alu_ctr   = ALU_SLT;
            end
`endif
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_ctr   = (w_opcode == OP_ANDI) ? ALU_AND :
                                   (w_opcode == OP_ORI)  ? ALU_OR  : ALU_XOR;
            end
            OP_LUI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.ext_op    = EXT_LUI;
            end
            OP_LW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
                w_ctrl.mem2reg   = 1'b1;
                w_ctrl.ext_op    = EXT_SIGN;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
                w_ctrl.ext_op    = EXT_SIGN;
            end
            OP_BEQ: begin
                w_ctrl.alu_ctr   = ALU_SUB;
                w_ctrl.npc_sel   = NPC_BEQ;
            end
            OP_J: begin
                // Jump only steers the PC; the ALU result is unused downstream.
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.npc_sel   = NPC_JUMP;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign w_srcB = w_ctrl.alu_src ? extend_imm(i_instr[15:0], w_ctrl.ext_op) : i_busB;

    mips_alu u_alu (
        .i_srcA   (i_busA),
        .i_srcB   (w_srcB),
        .i_aluCtr (w_ctrl.alu_ctr),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        r_pc_reset <= reset;
        if (reset) begin
            r_instr   <= '0;
            r_ctrl    <= '0;
            r_rw      <= '0;
            r_alu_res <= '0;
            r_zero    <= 1'b1;
        end else begin
            r_instr   <= i_instr;
            r_ctrl    <= w_ctrl;
            r_rw      <= w_ctrl.reg_dst ? i_instr[15:11] : i_instr[20:16];
            r_alu_res <= w_alu_res;
            r_zero    <= w_alu_zero;
        end
    end

    assign o_opcode   = r_instr[31:26];
    assign o_rs       = r_instr[25:21];
    assign o_rt       = r_instr[20:16];
    assign o_rd       = r_instr[15:11];
    assign o_shamt    = r_instr[10:6];
    assign o_funct    = r_instr[5:0];
    assign o_imm16    = r_instr[15:0];
    assign o_imm26    = r_instr[25:0];
    assign o_rw       = r_rw;
    assign o_aluResu  = r_alu_res;
    assign o_zero     = r_zero;
    assign o_regDst   = r_ctrl.reg_dst;
    assign o_aluSrc   = r_ctrl.alu_src;
    assign o_mem2Reg  = r_ctrl.mem2reg;
    assign o_memWrite = r_ctrl.mem_write;
    assign o_regWrite = r_ctrl.reg_write;
    assign o_aluCtr   = r_ctrl.alu_ctr;
    assign o_ext_op   = r_ctrl.ext_op;
    assign o_nPC_sel  = r_ctrl.npc_sel;
    assign o_pcReset  = r_pc_reset;

endmodule

// File: tb/tb_mips_decode_exec.sv
// ---------------------------------------------------------------------------
// tb_mips_decode_exec
// Self-checking bench for mips_decode_exec. A behavioural model computes the
// architectural result of each instruction directly; a compare process checks
// every output one edge later. Directed cases pin the model with literals.
// ---------------------------------------------------------------------------
module tb_mips_decode_exec;

`ifdef MIPS_SLT_EN
    localparam bit SLT_EN = 1'b1;
`else
    localparam bit SLT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = '0;
    logic [31:0] busA = '0;
    logic [31:0] busB = '0;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt, rw;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] aluResu;
    logic        zero, regDst, aluSrc, mem2Reg, memWrite, regWrite, pcReset;
    logic [2:0]  aluCtr;
    logic [1:0]  ext_op, nPC_sel;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_decode_exec dut (
        .clk        (clk),
        .reset      (reset),
        .i_instr    (instr),
        .i_busA     (busA),
        .i_busB     (busB),
        .o_opcode   (opcode),
        .o_funct    (funct),
        .o_rs       (rs),
        .o_rt       (rt),
        .o_rd       (rd),
        .o_shamt    (shamt),
        .o_imm16    (imm16),
        .o_imm26    (imm26),
        .o_rw       (rw),
        .o_aluResu  (aluResu),
        .o_zero     (zero),
        .o_regDst   (regDst),
        .o_aluSrc   (aluSrc),
        .o_mem2Reg  (mem2Reg),
        .o_memWrite (memWrite),
        .o_regWrite (regWrite),
        .o_aluCtr   (aluCtr),
        .o_ext_op   (ext_op),
        .o_nPC_sel  (nPC_sel),
        .o_pcReset  (pcReset)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic [4:0]  rw;
        logic        zero, reg_dst, alu_src, m2r, mw, rwe, pcr;
        logic [2:0]  ctr;
        logic [1:0]  ext, npc;
    } exp_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: what each instruction must produce.
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] a,
                                   input logic [31:0] b, input logic rst);
        exp_t e;
        logic [31:0] simm, zimm;
        simm = {{16{i[15]}}, i[15:0]};
        zimm = {16'h0, i[15:0]};
        e = '{ins: i, res: a + b, rw: i[20:16], zero: 1'b0, reg_dst: 1'b0,
              alu_src: 1'b0, m2r: 1'b0, mw: 1'b0, rwe: 1'b0, pcr: rst,
              ctr: 3'd0, ext: 2'd0, npc: 2'd0};
        if (rst) begin
            e.ins = '0; e.res = '0; e.rw = '0;
        end else begin
            case (i[31:26])
                6'h00: begin
                    e.reg_dst = 1'b1; e.rwe = 1'b1; e.rw = i[15:11];
                    case (i[5:0])
                        6'h20, 6'h21: begin e.ctr = 3'd0; e.res = a + b; end
                        6'h22, 6'h23: begin e.ctr = 3'd1; e.res = a - b; end
                        6'h24: begin e.ctr = 3'd2; e.res = a & b; end
                        6'h25: begin e.ctr = 3'd3; e.res = a | b; end
                        6'h26: begin e.ctr = 3'd4; e.res = a ^ b; end
                        6'h27: begin e.ctr = 3'd5; e.res = ~(a | b); end
                        6'h2A: begin e.ctr = 3'd6; e.res = ($signed(a) < $signed(b)) ? 1 : 0; end
                        6'h2B: begin e.ctr = 3'd7; e.res = (a < b) ? 1 : 0; end
                        default: begin e.reg_dst = 1'b0; e.rwe = 1'b0; e.rw = i[20:16]; end
                    endcase
                    if (!SLT_EN && (i[5:0] == 6'h2A || i[5:0] == 6'h2B)) begin
                        e.reg_dst = 1'b0; e.rwe = 1'b0; e.rw = i[20:16];
                        e.ctr = 3'd0; e.res = a + b;
                    end
                end
                6'h08, 6'h09: begin e.alu_src = 1; e.rwe = 1; e.ext = 2'd1; e.res = a + simm; end
                6'h0A: if (SLT_EN) begin
                    e.alu_src = 1; e.rwe = 1; e.ext = 2'd1; e.ctr = 3'd6;
                    e.res = ($signed(a) < $signed(simm)) ? 1 : 0;
                end
                6'h0C: begin e.alu_src = 1; e.rwe = 1; e.ctr = 3'd2; e.res = a & zimm; end
                6'h0D: begin e.alu_src = 1; e.rwe = 1; e.ctr = 3'd3; e.res = a | zimm; end
                6'h0E: begin e.alu_src = 1; e.rwe = 1; e.ctr = 3'd4; e.res = a ^ zimm; end
                6'h0F: begin e.alu_src = 1; e.rwe = 1; e.ext = 2'd2; e.res = a + {i[15:0], 16'h0}; end
                6'h23: begin e.alu_src = 1; e.rwe = 1; e.m2r = 1; e.ext = 2'd1; e.res = a + simm; end
                6'h2B: begin e.alu_src = 1; e.mw = 1; e.ext = 2'd1; e.res = a + simm; end
                6'h04: begin e.ctr = 3'd1; e.npc = 2'd1; e.res = a - b; end
                6'h02: begin e.alu_src = 1; e.npc = 2'd2; e.res = a + zimm; end
                default: ;
            endcase
        end
        e.zero = (e.res == 0);
        return e;
    endfunction

    // Compare process: model the inputs present at each edge, check after it.
    always @(posedge clk) begin
        exp_t e;
        e = model(instr, busA, busB, reset);
        #1;
        check("opcode",   {26'd0, opcode},  {26'd0, e.ins[31:26]});
        check("funct",    {26'd0, funct},   {26'd0, e.ins[5:0]});
        check("rs",       {27'd0, rs},      {27'd0, e.ins[25:21]});
        check("rt",       {27'd0, rt},      {27'd0, e.ins[20:16]});
        check("rd",       {27'd0, rd},      {27'd0, e.ins[15:11]});
        check("shamt",    {27'd0, shamt},   {27'd0, e.ins[10:6]});
        check("imm16",    {16'd0, imm16},   {16'd0, e.ins[15:0]});
        check("imm26",    {6'd0, imm26},    {6'd0, e.ins[25:0]});
        check("rw",       {27'd0, rw},      {27'd0, e.rw});
        check("aluResu",  aluResu,          e.res);
        check("zero",     {31'd0, zero},    {31'd0, e.zero});
        check("regDst",   {31'd0, regDst},  {31'd0, e.reg_dst});
        check("aluSrc",   {31'd0, aluSrc},  {31'd0, e.alu_src});
        check("mem2Reg",  {31'd0, mem2Reg}, {31'd0, e.m2r});
        check("memWrite", {31'd0, memWrite},{31'd0, e.mw});
        check("regWrite", {31'd0, regWrite},{31'd0, e.rwe});
        check("aluCtr",   {29'd0, aluCtr},  {29'd0, e.ctr});
        check("ext_op",   {30'd0, ext_op},  {30'd0, e.ext});
        check("nPC_sel",  {30'd0, nPC_sel}, {30'd0, e.npc});
        check("pcReset",  {31'd0, pcReset}, {31'd0, e.pcr});
    end

    task automatic drive(input logic [31:0] i, input logic [31:0] a,
                         input logic [31:0] b, input logic rst);
        @(negedge clk);
        instr = i; busA = a; busB = b; reset = rst;
    endtask

    // Drive, let the edge happen, then settle past the compare process.
    task automatic step(input logic [31:0] i, input logic [31:0] a,
                        input logic [31:0] b, input logic rst);
        drive(i, a, b, rst);
        @(posedge clk);
        #2;
    endtask

    logic [5:0] op_tab [13] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h09, 6'h0A,
                                6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h3F};
    logic [5:0] fn_tab [11] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                                6'h26, 6'h27, 6'h2A, 6'h2B, 6'h01};

    initial begin
        // Reset held for two edges.
        step(32'h0, 32'h0, 32'h0, 1'b1);
        step(32'hFFFF_FFFF, 32'h1, 32'h2, 1'b1);
        check("rst_pcReset", {31'd0, pcReset}, 32'd1);
        check("rst_zero",    {31'd0, zero},    32'd1);
        check("rst_aluResu", aluResu,          32'd0);
        check("rst_regWrite",{31'd0, regWrite},32'd0);

        // addu $3,$1,$2 with 5 + 7; also the first edge out of reset.
        step(32'h0022_1821, 32'd5, 32'd7, 1'b0);
        check("addu_pcReset", {31'd0, pcReset}, 32'd0);
        check("addu_res",     aluResu, 32'd12);
        check("addu_rw",      {27'd0, rw}, 32'd3);
        check("addu_regDst",  {31'd0, regDst}, 32'd1);
        check("addu_aluCtr",  {29'd0, aluCtr}, 32'd0);

        // ori zero-extends 0x8000.
        step(32'h3422_8000, 32'h1, 32'h0, 1'b0);
        check("ori_res", aluResu, 32'h0000_8001);
        check("ori_ext", {30'd0, ext_op}, 32'd0);
        check("ori_rw",  {27'd0, rw}, 32'd2);

        // lw sign-extends -4.
        step(32'h8C22_FFFC, 32'h100, 32'h0, 1'b0);
        check("lw_res",  aluResu, 32'h0000_00FC);
        check("lw_m2r",  {31'd0, mem2Reg}, 32'd1);

        // beq taken / not taken.
        step(32'h1022_0000, 32'h1234, 32'h1234, 1'b0);
        check("beq_zero", {31'd0, zero}, 32'd1);
        check("beq_npc",  {30'd0, nPC_sel}, 32'd1);
        step(32'h1022_0000, 32'h1234, 32'h1235, 1'b0);
        check("beq_nz",   {31'd0, zero}, 32'd0);

        // slt / sltu on -1 vs 1.
        step(32'h0022_182A, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("slt_res", aluResu, SLT_EN ? 32'd1 : 32'd0);
        check("slt_rwe", {31'd0, regWrite}, SLT_EN ? 32'd1 : 32'd0);
        step(32'h0022_182B, 32'hFFFF_FFFF, 32'd1, 1'b0);
        check("sltu_res", aluResu, SLT_EN ? 32'd0 : 32'd0);
        check("sltu_rwe", {31'd0, regWrite}, SLT_EN ? 32'd1 : 32'd0);

        // Unknown opcode, then reset on the same edge as a sw.
        step(32'hFC00_0000, 32'h5, 32'h6, 1'b0);
        check("unk_rwe", {31'd0, regWrite}, 32'd0);
        check("unk_npc", {30'd0, nPC_sel}, 32'd0);
        step(32'hAC22_0004, 32'h10, 32'h0, 1'b1);
        check("sw_rst_mw", {31'd0, memWrite}, 32'd0);
        step(32'hAC22_0004, 32'h10, 32'h0, 1'b0);
        check("sw_mw",  {31'd0, memWrite}, 32'd1);
        check("sw_res", aluResu, 32'h14);

        // Randomised stream checked by the compare process.
        for (int n = 0; n < 400; n++) begin
            logic [31:0] ri, ra, rb;
            logic        rr;
            ri = $urandom;
            ri[31:26] = op_tab[$urandom_range(0, 12)];
            if (ri[31:26] == 6'h00) ri[5:0] = fn_tab[$urandom_range(0, 10)];
            ra = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra ^ 32'h8000_0000;
            rr = ($urandom_range(0, 29) == 0);
            drive(ri, ra, rb, rr);
        end
        step(32'h0, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
